// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the core-side fetch/data handshakes and the
// external memory handshake of mem_port_arbiter.
//   Fetch port : if_req, if_addr -> if_ack, if_err, if_rdata
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_ack, d_err, d_rdata
//   Memory port: mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
//   Status     : busy
// Modport slave is the arbiter's view; modport master is the surrounding
// system (core plus memory) view.
interface mem_port_arbiter_if #(
  parameter int unsigned Width = 32
);
  logic             if_req;
  logic [Width-1:0] if_addr;
  logic             if_ack;
  logic             if_err;
  logic [Width-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [Width-1:0] d_addr;
  logic [Width-1:0] d_wdata;
  logic             d_ack;
  logic             d_err;
  logic [Width-1:0] d_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [Width-1:0] mem_addr;
  logic [Width-1:0] mem_wdata;
  logic             mem_ack;
  logic [Width-1:0] mem_rdata;

  logic             busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the data load/store port. One transaction in flight,
// round-robin on simultaneous requests, optional ack timeout that completes
// the transaction with an error response. All outputs are registered.
// Ports:
//   clk   - clock, rising edge
//   PCrst - asynchronous active-high reset
//   bus   - mem_port_arbiter_if.slave (fetch, data and memory handshakes, busy)
// Parameters:
//   Width   - address/data width
//   TIMEOUT - WAIT cycles before giving up on mem_ack; 0 disables the timeout
module mem_port_arbiter #(
  parameter int unsigned Width   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                PCrst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned CntW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam int unsigned LastCntI  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LastCntI);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // grant encoding: 0 = fetch, 1 = data
  localparam logic GntIf = 1'b0;
  localparam logic GntD  = 1'b1;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [Width-1:0] mem_addr_q, mem_addr_d;
  logic [Width-1:0] mem_wdata_q, mem_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             if_err_q, if_err_d;
  logic [Width-1:0] if_rdata_q, if_rdata_d;
  logic             d_ack_q, d_ack_d;
  logic             d_err_q, d_err_d;
  logic [Width-1:0] d_rdata_q, d_rdata_d;
  logic             busy_q, busy_d;
  logic             sel;

  // Next-state and output logic. Ack/err are raised on the WAIT->RESP
  // transition so the registered pulse lines up exactly with the RESP cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    sel         = GntIf;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // single requester wins; on a tie the port not served last wins
          if (bus.if_req && bus.d_req) begin
            sel = ~last_q;
          end else begin
            sel = bus.d_req ? GntD : GntIf;
          end
          gnt_d       = sel;
          mem_req_d   = 1'b1;
          mem_we_d    = (sel == GntD) ? bus.d_we : 1'b0;
          mem_addr_d  = (sel == GntD) ? bus.d_addr : bus.if_addr;
          mem_wdata_d = (sel == GntD) ? bus.d_wdata : '0;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (gnt_q == GntD) begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else if (TimeoutEn && (cnt_q == LastCnt)) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (gnt_q == GntD) begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
          end
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge PCrst) begin
    if (PCrst) begin
      state_q     <= IDLE;
      gnt_q       <= GntIf;
      last_q      <= GntD;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the CPU core's fetch/data paths and the external memory. Lets the core run on one memory, stalling on `if_ack`/`d_ack`.
- One outstanding memory transaction at a time; round-robin on simultaneous requests; optional ack timeout with error response.

Parameters:
- Width, 32, address/data width (matches core register width).
- TIMEOUT, 16, max cycles to wait for `mem_ack` in WAIT; 0 disables timeout.

Ports:
- clk  input  1  clock, rising edge.
- PCrst  input  1  reset, asynchronous, active-high.
- if_req  input  1  fetch request; held high and stable until `if_ack`.
- if_addr  input  Width  fetch address.
- if_ack  output  1  one-cycle pulse, fetch transaction complete.
- if_err  output  1  one-cycle pulse with `if_ack`, fetch timed out.
- if_rdata  output  Width  fetched word; valid when `if_ack`=1.
- d_req  input  1  data request; held high and stable until `d_ack`.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  Width  data address.
- d_wdata  input  Width  store data.
- d_ack  output  1  one-cycle pulse, data transaction complete.
- d_err  output  1  one-cycle pulse with `d_ack`, data timed out.
- d_rdata  output  Width  load data; valid when `d_ack`=1.
- mem_req  output  1  memory request; held high until `mem_ack`.
- mem_we  output  1  memory write enable.
- mem_addr  output  Width  memory address.
- mem_wdata  output  Width  memory write data.
- mem_ack  input  1  memory completion pulse; read data valid same cycle.
- mem_rdata  input  Width  memory read data.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- **Reset** (async, immediate): state=IDLE, last_grant=D, timeout counter=0. All outputs 0, including `mem_req` (drops mid-transaction) and both rdata registers. No pending response survives reset.
- **Registers:** all outputs are registers; no combinational path from inputs to outputs.
- **IDLE:**
  - If `if_req` or `d_req`: choose grant. A single requester wins outright. If both request, grant the one opposite `last_grant`.
  - Latch grant, addr, we (`we`=0 for IF), wdata (`wdata`=0 for IF) into `mem_*`.
  - Set `mem_req`=1, clear counter, go to WAIT.
- **WAIT:**
  - `mem_req` held 1; `mem_*` stable.
  - If `mem_ack`: capture `mem_rdata` into the granted port's rdata (stores capture it too), drop `mem_req`, go to RESP with err=0.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: drop `mem_req`, set granted rdata=0, go to RESP with err=1.
  - Else counter+1.
- **RESP:**
  - Pulse ack (and err if set) to the granted port for exactly one cycle.
  - Set last_grant=granted port; go to IDLE.
  - `mem_req`=0. `mem_ack` is ignored.
- **Latency:** `mem_ack` on the first WAIT cycle gives ack 2 cycles after req is sampled in IDLE. Requester drops req the cycle after ack, so IDLE never re-grants a finished request.
- **Ack outside WAIT:** `mem_ack` in IDLE or RESP (e.g. a late ack after a timeout) is ignored; no state change.
- **Request changes:** a req asserted while the other port is in service waits; it is served on the next IDLE. A req deasserted before grant is not served. Address/data changes while req is high and not yet granted are allowed; values are sampled only at grant.
- **Unused outputs:** rdata of the non-granted port is unchanged. ack/err are 0 outside RESP.
- **Counter:** width clog2(TIMEOUT+1), minimum 1; never wraps (bounded by TIMEOUT-1).

Test Plan:
- IF-only read: `if_req`=1, `if_addr`=0x00000004; memory acks 1st WAIT cycle with 0x00A00093. Expected: `mem_req` high 1 cycle, `mem_we`=0, `if_ack` pulse 2 cycles after req, `if_rdata`=0x00A00093, `if_err`=0.
- Tie after reset: `if_req`/`d_req` both rise the same cycle. Expected: IF granted first (last_grant reset = D), D granted in the following IDLE. Tie again: IF wins again (last_grant=D). Hold `d_req` continuously and re-raise `if_req`: grants alternate.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF; memory acks after 3 cycles. Expected: `mem_we`=1, `mem_wdata`=0xDEADBEEF held stable for all 3 WAIT cycles, `d_ack` 1 cycle after `mem_ack`.
- Timeout, TIMEOUT=4, memory never acks. Expected: `mem_req` high exactly 4 cycles, then `d_ack`=`d_err`=1 for one cycle, `d_rdata`=0. A `mem_ack` injected 2 cycles later is ignored (`busy`=0, no ack).
- Reset mid-WAIT: assert PCrst between clock edges while `mem_req`=1. Expected: `mem_req`, `busy`, acks, rdata all go to 0 immediately, no ack pulse after release. Next request completes normally.
- TIMEOUT=0, `mem_ack` after 40 cycles. Expected: no error; `mem_req` held for 40 cycles; normal ack with data.
